// File: rtl/rf_core.sv
`default_nettype none
// ============================================================================
// Module      : rf_core
// Description : 32 x 8-bit AVR register file with two byte read ports, one
//               aligned word read port and X/Y/Z pointer outputs.
//               Optional macro RF_BYPASS_EN enables write-through bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_core #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  waddr,
    input  logic [15:0] wdata,
    input  logic        we_byte,
    input  logic        we_word,
    input  logic [4:0]  raddr_d,
    input  logic [4:0]  raddr_r,
    input  logic [4:0]  raddr_w,
    output logic [7:0]  rdata_d,
    output logic [7:0]  rdata_r,
    output logic [15:0] rdata_w,
    output logic [15:0] reg_x,
    output logic [15:0] reg_y,
    output logic [15:0] reg_z
);

    logic [7:0] regs_q [32];
    logic [7:0] regs_d [32];
    logic [7:0] view   [32];

    logic       w_wen_a;
    logic       w_wen_b;
    logic [4:0] w_addr_a;
    logic [4:0] w_addr_b;
    logic [7:0] w_data_a;
    logic [7:0] w_data_b;

    // Lane A carries the low/only byte, lane B the high byte of a word write.
    always_comb begin
        w_wen_a  = 1'b0;
        w_wen_b  = 1'b0;
        w_addr_a = waddr;
        w_addr_b = waddr | 5'd1;
        w_data_a = wdata[7:0];
        w_data_b = wdata[15:8];
        if (we_word) begin
            w_wen_a  = 1'b1;
            w_wen_b  = 1'b1;
            w_addr_a = waddr & 5'h1E;
        end else if (we_byte) begin
            w_wen_a  = 1'b1;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (w_wen_a) begin
            regs_d[w_addr_a] = w_data_a;
        end
        if (w_wen_b) begin
            regs_d[w_addr_b] = w_data_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef RF_BYPASS_EN
    // Next-state already holds the merged write, so it doubles as the bypass view.
    always_comb begin
        if (rst) begin
            view = regs_q;
        end else begin
            view = regs_d;
        end
    end
`else
    always_comb begin
        view = regs_q;
    end
`endif

    assign rdata_d = view[raddr_d];
    assign rdata_r = view[raddr_r];
    assign rdata_w = {view[raddr_w | 5'd1], view[raddr_w & 5'h1E]};
    assign reg_x   = {view[27], view[26]};
    assign reg_y   = {view[29], view[28]};
    assign reg_z   = {view[31], view[30]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(we_byte && we_word))
                else $warning("rf_core: we_byte and we_word both set, byte write discarded");
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_core
// Description : Vector-table bench for rf_core (default and RF_BYPASS_EN builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_core;

    logic        clk;
    logic        rst;
    logic [4:0]  waddr;
    logic [15:0] wdata;
    logic        we_byte;
    logic        we_word;
    logic [4:0]  raddr_d;
    logic [4:0]  raddr_r;
    logic [4:0]  raddr_w;
    logic [7:0]  rdata_d;
    logic [7:0]  rdata_r;
    logic [15:0] rdata_w;
    logic [15:0] reg_x;
    logic [15:0] reg_y;
    logic [15:0] reg_z;

    int n_cmp;
    int n_err;

    rf_core #(.RESET_VAL(8'h00)) dut (
        .clk     (clk),
        .rst     (rst),
        .waddr   (waddr),
        .wdata   (wdata),
        .we_byte (we_byte),
        .we_word (we_word),
        .raddr_d (raddr_d),
        .raddr_r (raddr_r),
        .raddr_w (raddr_w),
        .rdata_d (rdata_d),
        .rdata_r (rdata_r),
        .rdata_w (rdata_w),
        .reg_x   (reg_x),
        .reg_y   (reg_y),
        .reg_z   (reg_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wb;
        logic        ww;
        logic [4:0]  wa;
        logic [15:0] wd;
        logic [4:0]  rd;
        logic [4:0]  rr;
        logic [4:0]  rw;
        logic [7:0]  exp_d;
        logic [7:0]  exp_r;
        logic [15:0] exp_w;
        logic [15:0] exp_x;
        logic [15:0] exp_y;
        logic [15:0] exp_z;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we_byte = 1'b0;
        we_word = 1'b0;
        waddr   = 5'd0;
        wdata   = 16'h0000;
    endtask

    task automatic byte_write(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        we_byte = 1'b1;
        we_word = 1'b0;
        waddr   = a;
        wdata   = d;
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        // wb ww wa wd rd rr rw exp_d exp_r exp_w exp_x exp_y exp_z
        vecs[0] = '{1'b1, 1'b0, 5'd17, 16'hFF5A, 5'd17, 5'd16, 5'd18, 8'h5A, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 5'd27, 16'h1234, 5'd26, 5'd27, 5'd26, 8'h34, 8'h12, 16'h1234, 16'h1234, 16'h0000, 16'h0000};
        vecs[2] = '{1'b1, 1'b1, 5'd24, 16'hBEEF, 5'd24, 5'd25, 5'd25, 8'hEF, 8'hBE, 16'hBEEF, 16'h1234, 16'h0000, 16'h0000};
        vecs[3] = '{1'b0, 1'b1, 5'd0,  16'hC3A5, 5'd0,  5'd1,  5'd1,  8'hA5, 8'hC3, 16'hC3A5, 16'h1234, 16'h0000, 16'h0000};
        vecs[4] = '{1'b1, 1'b0, 5'd31, 16'h4499, 5'd31, 5'd30, 5'd30, 8'h99, 8'h00, 16'h9900, 16'h1234, 16'h0000, 16'h9900};
        vecs[5] = '{1'b0, 1'b1, 5'd30, 16'hABCD, 5'd30, 5'd31, 5'd31, 8'hCD, 8'hAB, 16'hABCD, 16'h1234, 16'h0000, 16'hABCD};
        vecs[6] = '{1'b0, 1'b0, 5'd30, 16'hFFFF, 5'd17, 5'd26, 5'd0,  8'h5A, 8'h34, 16'hC3A5, 16'h1234, 16'h0000, 16'hABCD};
        vecs[7] = '{1'b1, 1'b0, 5'd28, 16'h337E, 5'd28, 5'd29, 5'd28, 8'h7E, 8'h00, 16'h007E, 16'h1234, 16'h007E, 16'hABCD};

        rst     = 1'b1;
        raddr_d = 5'd0;
        raddr_r = 5'd0;
        raddr_w = 5'd0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset overrides a simultaneous byte write
        byte_write(5'd5, 16'h003C);
        raddr_d = 5'd5;
        #1;
        chk("preload_r5", {8'h00, rdata_d}, 16'h003C);
        @(negedge clk);
        rst     = 1'b1;
        we_byte = 1'b1;
        waddr   = 5'd5;
        wdata   = 16'h00AA;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        raddr_r = 5'd4;
        raddr_w = 5'd5;
        #1;
        chk("rst_rdata_d", {8'h00, rdata_d}, 16'h0000);
        chk("rst_rdata_r", {8'h00, rdata_r}, 16'h0000);
        chk("rst_rdata_w", rdata_w, 16'h0000);
        chk("rst_reg_x", reg_x, 16'h0000);
        chk("rst_reg_y", reg_y, 16'h0000);
        chk("rst_reg_z", reg_z, 16'h0000);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            we_byte = vecs[i].wb;
            we_word = vecs[i].ww;
            waddr   = vecs[i].wa;
            wdata   = vecs[i].wd;
            @(posedge clk);
            #1;
            idle();
            raddr_d = vecs[i].rd;
            raddr_r = vecs[i].rr;
            raddr_w = vecs[i].rw;
            #1;
            chk($sformatf("v%0d_rdata_d", i), {8'h00, rdata_d}, {8'h00, vecs[i].exp_d});
            chk($sformatf("v%0d_rdata_r", i), {8'h00, rdata_r}, {8'h00, vecs[i].exp_r});
            chk($sformatf("v%0d_rdata_w", i), rdata_w, vecs[i].exp_w);
            chk($sformatf("v%0d_reg_x", i), reg_x, vecs[i].exp_x);
            chk($sformatf("v%0d_reg_y", i), reg_y, vecs[i].exp_y);
            chk($sformatf("v%0d_reg_z", i), reg_z, vecs[i].exp_z);
        end

        // Same-cycle read of the write target
        byte_write(5'd30, 16'h0011);
        @(negedge clk);
        raddr_r = 5'd30;
        we_byte = 1'b1;
        waddr   = 5'd30;
        wdata   = 16'h0077;
        #1;
`ifdef RF_BYPASS_EN
        chk("same_cycle_r30", {8'h00, rdata_r}, 16'h0077);
        chk("same_cycle_reg_z", reg_z, 16'hAB77);
`else
        chk("same_cycle_r30", {8'h00, rdata_r}, 16'h0011);
        chk("same_cycle_reg_z", reg_z, 16'hAB11);
`endif
        @(posedge clk);
        #1;
        idle();
        #1;
        chk("after_write_r30", {8'h00, rdata_r}, 16'h0077);
        chk("after_write_reg_z", reg_z, 16'hAB77);

        // Reset during a word write: nothing of the write survives
        @(negedge clk);
        rst     = 1'b1;
        we_word = 1'b1;
        waddr   = 5'd26;
        wdata   = 16'h5566;
        #1;
        chk("rst_no_bypass_x", reg_x, 16'h1234);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        raddr_d = 5'd17;
        raddr_w = 5'd0;
        #1;
        chk("rst2_reg_x", reg_x, 16'h0000);
        chk("rst2_reg_z", reg_z, 16'h0000);
        chk("rst2_rdata_d", {8'h00, rdata_d}, 16'h0000);
        chk("rst2_rdata_w", rdata_w, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
